// File: rtl/adma_desc_fetch.sv
// ADMA2 descriptor fetch engine: issues pipelined RAM word reads, assembles a 2- or 3-word
// descriptor, checks its valid bit and presents the decoded fields over valid/ready.
module adma_desc_fetch #(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              start,
   input  logic              abort,
   input  logic              mode64,
   input  logic [ADDR_W-1:0] address,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_data,
   output logic              desc_valid,
   input  logic              desc_ready,
   output logic [5:0]        desc_attr,
   output logic [16:0]       desc_len,
   output logic [ADDR_W-1:0] desc_addr,
   output logic [ADDR_W-1:0] next_address,
   output logic              error,
   output logic              busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;
   typedef struct packed {
      logic       vld;
      logic [1:0] idx;
   } tag_t;

   state_e      state_q;
   logic        mode64_q;
   logic [1:0]  issue_idx_q;
   tag_t        tag_q [RD_LAT];
   logic [21:0] word0_q;  // only {word0[31:16], word0[5:0]} is ever used
   logic [31:0] word1_q;

   logic        start_mode64;
   logic [1:0]  last_idx;
   tag_t        tag_out;
   logic        last_word;
   logic [15:0] len_field;
   logic [63:0] addr_full;

   // A 32-bit address space has no use for the high descriptor word.
   assign start_mode64 = (ADDR_W > 32) && mode64;
   assign last_idx     = mode64_q ? 2'd2 : 2'd1;
   assign tag_out      = tag_q[RD_LAT-1];
   assign last_word    = tag_out.vld && (tag_out.idx == last_idx);
   assign len_field    = word0_q[21:6];
   // The last word is consumed straight off the RAM bus in the cycle it arrives.
   assign addr_full    = mode64_q ? {mem_data, word1_q} : {32'h0, mem_data};

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q      <= StIdle;
         mode64_q     <= 1'b0;
         issue_idx_q  <= '0;
         word0_q      <= '0;
         word1_q      <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
         mem_addr     <= '0;
         mem_rd       <= 1'b0;
         desc_valid   <= 1'b0;
         desc_attr    <= '0;
         desc_len     <= '0;
         desc_addr    <= '0;
         next_address <= '0;
         error        <= 1'b0;
         busy         <= 1'b0;
      end else begin
         error <= 1'b0;
         tag_q[0] <= '{vld: mem_rd, idx: issue_idx_q};
         for (int unsigned i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
         if (tag_out.vld && tag_out.idx == 2'd0) word0_q <= {mem_data[31:16], mem_data[5:0]};
         if (tag_out.vld && tag_out.idx == 2'd1) word1_q <= mem_data;

         if (abort) begin
            state_q    <= StIdle;
            mem_rd     <= 1'b0;
            desc_valid <= 1'b0;
            busy       <= 1'b0;
            for (int unsigned i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     mode64_q     <= start_mode64;
                     mem_addr     <= address;
                     mem_rd       <= 1'b1;
                     issue_idx_q  <= 2'd0;
                     next_address <= address + (start_mode64 ? ADDR_W'(12) : ADDR_W'(8));
                     busy         <= 1'b1;
                     state_q      <= StIssue;
                  end
               end
               StIssue: begin
                  if (issue_idx_q == last_idx) begin
                     mem_rd  <= 1'b0;
                     state_q <= StWait;
                  end else begin
                     issue_idx_q <= issue_idx_q + 2'd1;
                     mem_addr    <= mem_addr + ADDR_W'(4);
                  end
               end
               StWait: begin
                  if (last_word) begin
                     if (word0_q[0]) begin
                        desc_attr  <= word0_q[5:0];
                        desc_len   <= (len_field == 16'h0) ? 17'h10000 : {1'b0, len_field};
                        desc_addr  <= addr_full[ADDR_W-1:0];
                        desc_valid <= 1'b1;
                        state_q    <= StHold;
                     end else begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                     end
                  end
               end
               StHold: begin
                  if (desc_ready) begin
                     desc_valid <= 1'b0;
                     busy       <= 1'b0;
                     state_q    <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: doc/adma_desc_fetch.md
# adma_desc_fetch

Parametrised ADMA2 descriptor fetch engine: the next-generation replacement for the single-mode descriptor fetch unit. On `start` it issues pipelined word reads to system RAM, assembles one descriptor in 32-bit-address (2-word) or 64-bit-address (3-word) format, checks the valid bit, and presents the decoded fields to the ADMA state machine over a valid/ready handshake. It sits between the ADMA controller and the shared RAM port and supports configurable RAM read latency and abort.

## Interface
- `ADDR_W`, 64: system address width, 32 or 64. When 32, `mode64` is ignored and treated as 0.
- `RD_LAT`, 1: RAM read latency in cycles, 1..4. Data for a read issued in cycle t is on `mem_data` in cycle t+RD_LAT.

- `CLK`  in  1  clock, rising edge.
- `RESET_N`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a fetch; sampled only in IDLE.
- `abort`  in  1  synchronous abort; highest priority after reset.
- `mode64`  in  1  1 = 3-word descriptor, 0 = 2-word; sampled with `start`.
- `address`  in  ADDR_W  descriptor base byte address; sampled with `start`.
- `mem_addr`  out  ADDR_W  RAM word address being read.
- `mem_rd`  out  1  RAM read strobe.
- `mem_data`  in  32  RAM read data.
- `desc_valid`  out  1  decoded descriptor available.
- `desc_ready`  in  1  consumer accepts descriptor.
- `desc_attr`  out  6  word0[5:0]: valid, end, int, act[2:0].
- `desc_len`  out  17  byte length; word0[31:16], 0 encodes 65536.
- `desc_addr`  out  ADDR_W  {word2, word1}, truncated to ADDR_W; word2 treated as 0 in 2-word mode.
- `next_address`  out  ADDR_W  base + 8 (2-word) or base + 12 (3-word), modulo 2^ADDR_W.
- `error`  out  1  one-cycle pulse: fetched descriptor has valid bit = 0.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE: `start`=1 latches `address`, `mode64`; N = 3 if mode64 else 2; go ISSUE.
- ISSUE: `mem_rd`=1 for N consecutive cycles; `mem_addr` = base, base+4, base+8 (word k at base+4k, modulo 2^ADDR_W). After the last issue, go WAIT. No stall; RAM always accepts.
- Returned words are tracked by an RD_LAT-deep tag shift register (valid bit + word index). Each tagged word is captured into its word slot when the tag matures.
- WAIT: when word N-1 is captured, check word0[0]:
  - 1: load outputs, `desc_valid`=1, go HOLD.
  - 0: `error` pulses for one cycle, outputs stay unchanged, go IDLE.
- HOLD: outputs stable while `desc_valid`=1. On `desc_valid && desc_ready` transfer occurs, `desc_valid` drops next cycle, go IDLE. `start` is ignored outside IDLE.
- `next_address` is computed at `start` and valid from HOLD or error onward. It is held until the next `start`.
- `desc_len` = (word0[31:16]==0) ? 17'h10000 : {1'b0, word0[31:16]}.
- abort: any state goes to IDLE next cycle. Tag register cleared, so in-flight returns are discarded. `desc_valid`, `mem_rd` and `error` drop and no error is signalled. `abort` and `start` together in IDLE: abort wins and no fetch starts.
- Reset, asynchronous, mid-operation: all state cleared. In-flight RAM data is ignored after release.

## Timing
- Reset values: `mem_addr`=0, `mem_rd`=0, `desc_valid`=0, `desc_attr`=0, `desc_len`=0, `desc_addr`=0, `next_address`=0, `error`=0, `busy`=0; state IDLE.
- All outputs are registered.
- `start` sampled at edge E0. `mem_rd` is high from E0 to E0+N, one word per cycle.
- Last word captured at edge E0+N+RD_LAT. `desc_valid` or `error` is visible from that edge.
- Example: 3-word mode, RD_LAT=1 gives 4 cycles. 2-word mode, RD_LAT=3 gives 5 cycles.
- `desc_ready` held high in HOLD: transfer takes one cycle. IDLE is reached at the next edge and a new `start` is accepted there, giving back-to-back spacing of N+RD_LAT+2 cycles.
- `busy` rises at E0 and falls the edge after transfer, error or abort.

## Test plan
- 3-word, RD_LAT=1, base 0x100; RAM words 0x0200_0021, 0xDEAD_BEE0, 0x0000_0001 -> `mem_addr` 0x100/0x104/0x108; after 4 cycles `desc_valid`=1, `desc_attr`=0x21, `desc_len`=0x200, `desc_addr`=0x1_DEAD_BEE0, `next_address`=0x10C.
- 2-word, RD_LAT=3, base 0x40; word0=0x0000_0003, word1=0x1000 -> `desc_valid` after 5 cycles, `desc_len`=0x10000, `desc_addr`=0x1000, `next_address`=0x48.
- word0[0]=0 -> `error` high exactly one cycle, `desc_valid` never asserts, `busy` low next cycle.
- `desc_ready` low for 5 cycles in HOLD -> all outputs stable; ready high -> `desc_valid` low next cycle; second `start` accepted in IDLE.
- `abort` one cycle after last `mem_rd` with RD_LAT=2 -> IDLE next cycle, late `mem_data` ignored, no `desc_valid`/`error`. Repeat with `RESET_N` low mid-ISSUE -> all outputs 0 immediately.
- ADDR_W=32, `mode64`=1, base 0xFFFF_FFF8 -> only 2 reads, at 0xFFFF_FFF8/0xFFFF_FFFC; `next_address`=0x0000_0000 (wrap).
